// File: rtl/lb_master_arbiter.sv
// rtl/lb_master_arbiter.sv - round-robin arbiter sharing one local-bus master port among NUM_REQ requesters
// Optional acknowledge timeout enabled by defining LB_ARB_TIMEOUT_EN.
module lb_master_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [NUM_REQ-1:0]    req_vld_i,
   input  logic [NUM_REQ-1:0]    req_wr_i,
   input  logic [NUM_REQ*AW-1:0] req_adr_i,
   input  logic [NUM_REQ*DW-1:0] req_wdat_i,
   output logic [NUM_REQ-1:0]    req_ack_o,
   output logic                  req_err_o,
   output logic [DW-1:0]         req_rdat_o,
   output logic                  lb_wreq_o,
   output logic [AW-1:0]         lb_wadr_o,
   output logic [DW-1:0]         lb_wdat_o,
   input  logic                  lb_wack_i,
   output logic                  lb_rreq_o,
   output logic [AW-1:0]         lb_radr_o,
   input  logic [DW-1:0]         lb_rdat_i,
   input  logic                  lb_rack_i
);

   localparam int IW = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
      $error("lb_master_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

   state_t               state_q, state_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   logic [IW-1:0]        gnt_q, gnt_d;
   logic                 wr_q, wr_d;
   logic [AW-1:0]        adr_q, adr_d;
   logic [DW-1:0]        wdat_q, wdat_d;
   logic                 wreq_q, wreq_d;
   logic                 rreq_q, rreq_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic                 err_q, err_d;
   logic [DW-1:0]        rdat_q, rdat_d;
   logic                 found;
   logic [IW-1:0]        gnt_idx;
   logic [IW-1:0]        scan_idx;
   logic                 lb_ack;
   logic                 tmo_hit;
`ifdef LB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]        cnt_q, cnt_d;
`endif

   // First requesting index after the pointer, wrapping around.
   always_comb begin
      found    = 1'b0;
      gnt_idx  = ptr_q;
      scan_idx = ptr_q;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx = IW'((int'(ptr_q) + k) % NUM_REQ);
         if (!found && req_vld_i[scan_idx]) begin
            found   = 1'b1;
            gnt_idx = scan_idx;
         end
      end
   end

   // Only the ack of the active direction counts.
   assign lb_ack = wr_q ? lb_wack_i : lb_rack_i;

`ifdef LB_ARB_TIMEOUT_EN
   assign tmo_hit = (cnt_q == CW'(TIMEOUT - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      wr_d    = wr_q;
      adr_d   = adr_q;
      wdat_d  = wdat_q;
      wreq_d  = 1'b0;
      rreq_d  = 1'b0;
      ack_d   = '0;
      err_d   = 1'b0;
      rdat_d  = rdat_q;
`ifdef LB_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d = S_ISSUE;
               ptr_d   = gnt_idx;
               gnt_d   = gnt_idx;
               wr_d    = req_wr_i[gnt_idx];
               adr_d   = req_adr_i[gnt_idx*AW +: AW];
               wdat_d  = req_wdat_i[gnt_idx*DW +: DW];
               wreq_d  = req_wr_i[gnt_idx];
               rreq_d  = !req_wr_i[gnt_idx];
`ifdef LB_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         S_ISSUE: begin
            wreq_d = wr_q;
            rreq_d = !wr_q;
`ifdef LB_ARB_TIMEOUT_EN
            cnt_d  = cnt_q + 1'b1;
`endif
            if (lb_ack || tmo_hit) begin
               wreq_d  = 1'b0;
               rreq_d  = 1'b0;
               ack_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_q;
               state_d = S_GAP;
               if (lb_ack) begin
                  rdat_d = wr_q ? '0 : lb_rdat_i;
               end else begin
                  err_d  = 1'b1;
                  rdat_d = '1;
               end
            end
         end
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         ptr_q   <= IW'(NUM_REQ - 1);
         gnt_q   <= '0;
         wr_q    <= 1'b0;
         adr_q   <= '0;
         wdat_q  <= '0;
         wreq_q  <= 1'b0;
         rreq_q  <= 1'b0;
         ack_q   <= '0;
         err_q   <= 1'b0;
         rdat_q  <= '0;
`ifdef LB_ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         wr_q    <= wr_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         wreq_q  <= wreq_d;
         rreq_q  <= rreq_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdat_q  <= rdat_d;
`ifdef LB_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign req_ack_o  = ack_q;
   assign req_err_o  = err_q;
   assign req_rdat_o = rdat_q;
   assign lb_wreq_o  = wreq_q;
   assign lb_rreq_o  = rreq_q;
   assign lb_wadr_o  = adr_q;
   assign lb_radr_o  = adr_q;
   assign lb_wdat_o  = wdat_q;

endmodule

// File: tb/tb_lb_master_arbiter.sv
// tb/tb_lb_master_arbiter.sv - directed vector bench for lb_master_arbiter (TIMEOUT = 8)
module tb_lb_master_arbiter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   req_vld;
   logic [3:0]   req_wr;
   logic [127:0] req_adr;
   logic [127:0] req_wdat;
   logic [3:0]   req_ack;
   logic         req_err;
   logic [31:0]  req_rdat;
   logic         lb_wreq;
   logic [31:0]  lb_wadr;
   logic [31:0]  lb_wdat;
   logic         lb_wack;
   logic         lb_rreq;
   logic [31:0]  lb_radr;
   logic [31:0]  lb_rdat;
   logic         lb_rack;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   lb_master_arbiter #(.NUM_REQ(4), .AW(32), .DW(32), .TIMEOUT(8)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_vld_i(req_vld), .req_wr_i(req_wr), .req_adr_i(req_adr), .req_wdat_i(req_wdat),
      .req_ack_o(req_ack), .req_err_o(req_err), .req_rdat_o(req_rdat),
      .lb_wreq_o(lb_wreq), .lb_wadr_o(lb_wadr), .lb_wdat_o(lb_wdat), .lb_wack_i(lb_wack),
      .lb_rreq_o(lb_rreq), .lb_radr_o(lb_radr), .lb_rdat_i(lb_rdat), .lb_rack_i(lb_rack)
   );

   typedef struct {
      logic [3:0]  vld;
      logic [3:0]  wr;
      int          dly;
      logic [31:0] rdat;
      int          gnt;
      logic        wr_exp;
      logic [31:0] adr;
      logic [31:0] wdat;
      logic [31:0] exp_rdat;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_req(output int lowc, output bit seen);
      lowc = 0;
      seen = 1'b0;
      for (int w = 0; w < 10 && !seen; w++) begin
         @(negedge clk);
         if (lb_wreq || lb_rreq) seen = 1'b1;
         else lowc++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lowc;
      bit  seen;
      int  n;
      bit  got;

      vecs[0]  = '{4'b1111, 4'b1010, 2, 32'hCAFE_0000, 0, 1'b0, 32'h10, 32'h0, 32'hCAFE_0000};
      vecs[1]  = '{4'b1111, 4'b1010, 1, 32'hDEAD_BEEF, 1, 1'b1, 32'h18, 32'hA5A5_0002, 32'h0};
      vecs[2]  = '{4'b1111, 4'b1010, 0, 32'h1111_2222, 2, 1'b0, 32'h24, 32'h0, 32'h1111_2222};
      vecs[3]  = '{4'b1111, 4'b1010, 4, 32'hDEAD_BEEF, 3, 1'b1, 32'h3C, 32'hA5A5_0004, 32'h0};
      vecs[4]  = '{4'b1111, 4'b1010, 1, 32'h3333_4444, 0, 1'b0, 32'h10, 32'h0, 32'h3333_4444};
      vecs[5]  = '{4'b1111, 4'b1010, 0, 32'hDEAD_BEEF, 1, 1'b1, 32'h18, 32'hA5A5_0002, 32'h0};
      vecs[6]  = '{4'b0001, 4'b0001, 3, 32'hDEAD_BEEF, 0, 1'b1, 32'h10, 32'hA5A5_0001, 32'h0};
      vecs[7]  = '{4'b0100, 4'b0000, 1, 32'h1234_5678, 2, 1'b0, 32'h24, 32'h0, 32'h1234_5678};
      vecs[8]  = '{4'b1010, 4'b0000, 0, 32'h5555_6666, 3, 1'b0, 32'h3C, 32'h0, 32'h5555_6666};
      vecs[9]  = '{4'b1010, 4'b0010, 2, 32'hDEAD_BEEF, 1, 1'b1, 32'h18, 32'hA5A5_0002, 32'h0};
      vecs[10] = '{4'b1001, 4'b0000, 1, 32'h7777_8888, 3, 1'b0, 32'h3C, 32'h0, 32'h7777_8888};

      rst_n    = 1'b0;
      req_vld  = '0;
      req_wr   = '0;
      req_adr  = {32'h3C, 32'h24, 32'h18, 32'h10};
      req_wdat = {32'hA5A5_0004, 32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001};
      lb_wack  = 1'b0;
      lb_rack  = 1'b0;
      lb_rdat  = '0;

      repeat (3) @(negedge clk);
      chk("rst_ctrl", {26'd0, lb_wreq, lb_rreq, req_ack, req_err}, 32'h0);
      chk("rst_adr", lb_wadr, 32'h0);
      chk("rst_rdat", req_rdat, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) begin
         req_vld = vecs[i].vld;
         req_wr  = vecs[i].wr;
         wait_req(lowc, seen);
         chk($sformatf("v%0d_rise", i), {31'd0, seen}, 32'd1);
         chk($sformatf("v%0d_lowc", i), lowc, (i == 0) ? 32'd0 : 32'd1);
         chk($sformatf("v%0d_dir", i), {30'd0, lb_wreq, lb_rreq}, vecs[i].wr_exp ? 32'd2 : 32'd1);
         chk($sformatf("v%0d_adr", i), vecs[i].wr_exp ? lb_wadr : lb_radr, vecs[i].adr);
         if (vecs[i].wr_exp) chk($sformatf("v%0d_wdat", i), lb_wdat, vecs[i].wdat);
         repeat (vecs[i].dly) @(negedge clk);
         chk($sformatf("v%0d_noack", i), {28'd0, req_ack}, 32'd0);
         if (vecs[i].wr_exp) lb_wack = 1'b1;
         else lb_rack = 1'b1;
         lb_rdat = vecs[i].rdat;
         @(negedge clk);
         lb_wack = 1'b0;
         lb_rack = 1'b0;
         lb_rdat = '0;
         chk($sformatf("v%0d_ack", i), {28'd0, req_ack}, 32'd1 << vecs[i].gnt);
         chk($sformatf("v%0d_rdat", i), req_rdat, vecs[i].exp_rdat);
         chk($sformatf("v%0d_err", i), {31'd0, req_err}, 32'd0);
         chk($sformatf("v%0d_gaplow", i), {30'd0, lb_wreq, lb_rreq}, 32'd0);
      end
      req_vld = '0;
      req_wr  = '0;

      // Stray acks: write ack while idle, read ack during a write.
      @(negedge clk);
      lb_wack = 1'b1;
      @(negedge clk);
      lb_wack = 1'b0;
      chk("stray_idle_ack", {28'd0, req_ack}, 32'd0);
      chk("stray_idle_req", {30'd0, lb_wreq, lb_rreq}, 32'd0);
      req_vld = 4'b0001;
      req_wr  = 4'b0001;
      wait_req(lowc, seen);
      chk("stray_rise", {31'd0, seen}, 32'd1);
      lb_rack = 1'b1;
      lb_rdat = 32'hBAD0_BAD0;
      @(negedge clk);
      lb_rack = 1'b0;
      lb_rdat = '0;
      chk("stray_rack_ack", {28'd0, req_ack}, 32'd0);
      chk("stray_rack_wreq", {31'd0, lb_wreq}, 32'd1);
      @(negedge clk);
      lb_wack = 1'b1;
      @(negedge clk);
      lb_wack = 1'b0;
      req_vld = '0;
      chk("stray_done_ack", {28'd0, req_ack}, 32'd1);
      chk("stray_done_rdat", req_rdat, 32'd0);

      // Reset in the middle of a write.
      @(negedge clk);
      req_vld = 4'b0010;
      req_wr  = 4'b0010;
      wait_req(lowc, seen);
      chk("rstmid_rise", {31'd0, seen}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_async_drop", {31'd0, lb_wreq}, 32'd0);
      req_vld = '0;
      req_wr  = '0;
      @(negedge clk);
      lb_wack = 1'b1;
      @(negedge clk);
      lb_wack = 1'b0;
      chk("rstmid_noack", {28'd0, req_ack}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      lb_wack = 1'b1;
      @(negedge clk);
      lb_wack = 1'b0;
      chk("rstmid_late_ack", {28'd0, req_ack}, 32'd0);
      chk("rstmid_idle_req", {30'd0, lb_wreq, lb_rreq}, 32'd0);
      req_vld = 4'b1111;
      req_wr  = 4'b0000;
      wait_req(lowc, seen);
      chk("rstmid_regrant_rise", {31'd0, seen}, 32'd1);
      chk("rstmid_regrant_adr", lb_radr, 32'h10);
      lb_rack = 1'b1;
      lb_rdat = 32'h9999_AAAA;
      @(negedge clk);
      lb_rack = 1'b0;
      lb_rdat = '0;
      req_vld = '0;
      chk("rstmid_regrant_ack", {28'd0, req_ack}, 32'd1);
      chk("rstmid_regrant_rdat", req_rdat, 32'h9999_AAAA);

      // Read with no acknowledge.
      @(negedge clk);
      req_vld = 4'b1000;
      req_wr  = 4'b0000;
      wait_req(lowc, seen);
      chk("tmo_rise", {31'd0, seen}, 32'd1);
      chk("tmo_adr", lb_radr, 32'h3C);
`ifdef LB_ARB_TIMEOUT_EN
      n   = 0;
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         n++;
         if (req_ack != 4'd0) begin
            got = 1'b1;
            break;
         end
      end
      req_vld = '0;
      chk("tmo_got", {31'd0, got}, 32'd1);
      chk("tmo_cycles", n, 32'd8);
      chk("tmo_ack", {28'd0, req_ack}, 32'h8);
      chk("tmo_err", {31'd0, req_err}, 32'd1);
      chk("tmo_rdat", req_rdat, 32'hFFFF_FFFF);
      @(negedge clk);
      lb_rack = 1'b1;
      lb_rdat = 32'h0BAD_F00D;
      @(negedge clk);
      lb_rack = 1'b0;
      lb_rdat = '0;
      chk("tmo_late_ack", {28'd0, req_ack}, 32'd0);
      chk("tmo_late_req", {30'd0, lb_wreq, lb_rreq}, 32'd0);
`else
      n   = 0;
      got = 1'b0;
      repeat (20) @(negedge clk);
      chk("notmo_still_waiting", {28'd0, req_ack}, 32'd0);
      chk("notmo_rreq_held", {31'd0, lb_rreq}, 32'd1);
      lb_rack = 1'b1;
      lb_rdat = 32'h0BAD_F00D;
      @(negedge clk);
      lb_rack = 1'b0;
      lb_rdat = '0;
      req_vld = '0;
      chk("notmo_ack", {28'd0, req_ack}, 32'h8);
      chk("notmo_err", {31'd0, req_err}, 32'd0);
      chk("notmo_rdat", req_rdat, 32'h0BAD_F00D);
`endif

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
